// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the mode-0 SPI master.
package spi_pkg;
    localparam int FRAME_BITS  = 32;
    localparam int CLK_DIV_DEF = 4;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} spi_state_t;
endpackage

// File: rtl/spi_master_if.sv
// Request/response side of the SPI master: frame start, tx word, rx word and status.
import spi_pkg::*;

interface spi_master_if;
    logic                  start;
    logic [FRAME_BITS-1:0] d;
    logic [FRAME_BITS-1:0] q;
    logic                  busy;
    logic                  done;

    modport master (output start, d, input q, busy, done);
    modport slave  (input start, d, output q, busy, done);
endinterface

// File: rtl/spi_sck_gen.sv
// Half-period counter; emits a one-cycle strobe after CLK_DIV enabled cycles in each sck phase.
import spi_pkg::*;

module spi_sck_gen #(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sck_hi,
    output logic rise_tick,
    output logic fall_tick
);
    logic [7:0] cnt;
    logic       tick;

    assign tick      = en && (cnt == 8'(CLK_DIV - 1));
    assign rise_tick = tick && !sck_hi;
    assign fall_tick = tick && sck_hi;

    // Reload on every strobe so each phase is exactly CLK_DIV cycles; held at 0 outside LOW/HIGH.
    always_ff @(posedge clk) begin
        if (reset || !en || tick) cnt <= 8'd0;
        else                      cnt <= cnt + 8'd1;
    end
endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, one 32-bit full-duplex frame per start.
// Define SPI_CS_EN to add the active-low cs_n output.
import spi_pkg::*;

module spi_master #(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    spi_master_if.slave      bus,
    output logic             sck,
    output logic             sdo,
    input  logic             sdi
`ifdef SPI_CS_EN
    ,
    output logic             cs_n
`endif
);
    spi_state_t            state;
    logic [FRAME_BITS-1:0] tx;
    logic [FRAME_BITS-1:0] rx;
    logic [4:0]            bitcnt;
    logic                  rise_tick;
    logic                  fall_tick;
    logic                  cs_r;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (state == LOW || state == HIGH),
        .sck_hi    (state == HIGH),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

`ifdef SPI_CS_EN
    assign cs_n = cs_r;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= '0;
            rx       <= '0;
            bitcnt   <= 5'd0;
            sck      <= 1'b0;
            sdo      <= 1'b0;
            cs_r     <= 1'b1;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.q    <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    tx       <= bus.d;
                    sdo      <= bus.d[FRAME_BITS-1];
                    bitcnt   <= 5'd0;
                    bus.busy <= 1'b1;
                    cs_r     <= 1'b0;
                    state    <= LOW;
                end
                LOW: if (rise_tick) begin
                    sck   <= 1'b1;
                    rx    <= {rx[FRAME_BITS-2:0], sdi};
                    state <= HIGH;
                end
                HIGH: if (fall_tick) begin
                    sck    <= 1'b0;
                    tx     <= tx << 1;
                    // Next MSB is tx[30] before the shift; zeros fill in after the last bit.
                    sdo    <= tx[FRAME_BITS-2];
                    bitcnt <= bitcnt + 5'd1;
                    if (bitcnt == 5'(FRAME_BITS - 1)) begin
                        bus.q    <= rx;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= LOW;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    cs_r     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/spi_master.md
# spi_master

Clock-divided SPI master that runs one 32-bit full-duplex frame per request, driving `sck`/`sdo` and sampling `sdi` in mode 0: data changes on falling `sck` and is sampled on rising `sck`. It is the initiator end of the sensor sample link. In the heart-rate system it pushes a 32-bit word (voltage sample in bits [7:0]) to the FPGA's SPI slave input stage and captures the 32-bit word returned. It sits between the sample source (ADC capture or test pattern logic) and the board-level SPI pins.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `sck` half-period; legal range 1..255.
- `FRAME_BITS`, default 32: bits per frame; fixed at 32 for this link. Taken from the package constant.
- `clk`  in  1  system clock; the single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `d`  in  32  transmit word; latched on the accepted `start`.
- `sck`  out  1  serial clock to slave; idles low.
- `sdo`  out  1  master-out data, MSB first.
- `sdi`  in  1  master-in data from slave.
- `q`  out  32  last received word; held until the next frame completes.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse; `q` is valid in the same cycle.
- `cs_n`  out  1  active-low chip select; present only with `SPI_CS_EN`.

## Operation
- States:
  - IDLE -> LOW on `start`.
  - LOW -> HIGH after `CLK_DIV` cycles.
  - HIGH -> LOW after `CLK_DIV` cycles while fewer than 32 bits are complete.
  - HIGH -> DONE after `CLK_DIV` cycles once 32 bits are complete.
  - DONE -> IDLE unconditionally after 1 cycle.
- Accepted `start` (state IDLE):
  - tx shift register <= `d`.
  - `sdo` <= `d[31]`.
  - bit counter <= 0.
  - `busy` <= 1.
- LOW->HIGH transition: `sck` <= 1; rx shift register <= {rx[30:0], `sdi`}.
- HIGH->LOW/DONE transition:
  - `sck` <= 0.
  - tx shifts left by 1.
  - `sdo` <= next MSB (0 after the last bit).
  - bit counter increments.
- DONE: `q` <= rx; `done` = 1; `busy` stays 1 for this cycle; `sck` = 0.
- `start` is ignored in LOW, HIGH and DONE; there is no queuing. `d` changes after acceptance have no effect.
- Bit counter: 5 bits. Frame ends when the counter wraps 31 -> 0 on the 32nd falling edge.
- Half-period counter: 8 bits. It reloads to 0 on every `sck` transition and on frame start.

## Timing
- Reset values:
  - `sck`=0, `sdo`=0, `busy`=0, `done`=0, `q`=0, `cs_n`=1.
  - State IDLE; all internal counters and shift registers 0.
- `start` accepted at edge k:
  - first rising `sck` at k+`CLK_DIV`.
  - `done`=1 during cycle k+1+64·`CLK_DIV`.
- Throughput: the next `start` is accepted no earlier than the cycle after `done`. Minimum frame period is 2+64·`CLK_DIV` cycles.
- `sdi` is sampled by `clk` on the cycle `sck` rises, so the slave must present data at least one `clk` before the rising edge. The mode-0 falling-edge launch gives `CLK_DIV` cycles of margin.
- Reset mid-frame: the frame aborts in the same edge. `sck` drops to 0 and no `done` is issued. `q` returns to 0.
- `CLK_DIV`=1: `sck` = `clk`/2. Behaviour is otherwise identical.

## Configuration
- `SPI_CS_EN` defined:
  - `cs_n` port exists.
  - `cs_n` falls with the accepted `start` (same edge as `busy`) and rises on the DONE->IDLE edge.
  - This adds a guaranteed one-`clk` setup before the first rising `sck` and one `clk` of hold after the last falling `sck`.
- `SPI_CS_EN` undefined: no `cs_n` port. Frames are delimited only by the 32-clock count, which the slave's free-running bit counter relies on.

## Structure
- Package `spi_pkg`:
  - `FRAME_BITS` = 32.
  - `spi_state_t` enum {IDLE, LOW, HIGH, DONE}.
  - Default `CLK_DIV` constant.
- Sub-module `spi_sck_gen`:
  - Half-period counter producing `rise_tick`/`fall_tick` strobes.
  - Enabled by state LOW/HIGH; counter held at 0 otherwise.
- Top level: FSM, the two shift registers, the bit counter and the `q` register.

## Test plan
- Loopback (`sdi` tied to `sdo`), `CLK_DIV`=4, `d`=0xA5C3_0F96 -> `done` at 257 cycles after the `start` edge; `q`=0xA5C3_0F96; exactly 32 `sck` rising edges.
- Slave model returns 0x1234_5678 while `d`=0x0000_00FF -> `q`=0x1234_5678; the slave captures 0x0000_00FF; `sdo` changes only while `sck` is low.
- `start` held high continuously -> back-to-back frames, each 258 cycles apart. `start` during busy causes no restart or glitch on `sck`.
- `reset` asserted at bit 17 -> next edge gives `sck`=0, `busy`=0, `q`=0 and no `done`. A new `start` afterwards completes a correct full frame.
- `CLK_DIV`=1, `d`=0xFFFF_FFFF, `sdi`=0 -> `done` at cycle 65; `q`=0; `sck` toggles every `clk`.
- `SPI_CS_EN` build -> `cs_n` low from the `start`-accept edge through DONE, and high in IDLE and under reset.
